// File: rtl/model_pkg.sv
// model_pkg: shared model memory definitions.
// Used by the loader and by the model memory write port.
package model_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int MAX_RECORDS = 4096;

  typedef enum logic [1:0] {
    IndexTarget    = 2'd0,
    PositionTarget = 2'd1,
    NormalTarget   = 2'd2
  } target_e;

  // Bytes per record for a target.
  function automatic logic [3:0] rec_len(input target_e t);
    return (t == IndexTarget) ? 4'd6 : 4'd12;
  endfunction

endpackage

// File: rtl/loader_record_packer.sv
// loader_record_packer: assembles stream bytes into one record.
// last_out flags the final byte; data_out already includes it.
module loader_record_packer
  import model_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clr_in,
  input  logic             en_in,
  input  logic [7:0]       byte_in,
  input  target_e          target_in,
  output logic             last_out,
  output logic [2:0][31:0] data_out
);

  logic [3:0]       cnt_q;
  logic [11:0][7:0] buf_q;
  logic [11:0][7:0] buf_d;

  // Current byte merged into the record buffer.
  always_comb begin
    buf_d = buf_q;
    if (en_in) buf_d[cnt_q] = byte_in;
  end

  assign last_out = en_in &&
    (cnt_q == rec_len(target_in) - 4'd1);

  // Lane packing: 12-bit indices or raw fp32 words.
  always_comb begin
    data_out = '0;
    for (int k = 0; k < 3; k++) begin
      if (target_in == IndexTarget)
        data_out[k] = {20'd0,
                       buf_d[2*k+1][3:0],
                       buf_d[2*k]};
      else
        data_out[k] = {buf_d[4*k+3], buf_d[4*k+2],
                       buf_d[4*k+1], buf_d[4*k]};
    end
  end

  // Byte-within-record counter and buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      cnt_q <= '0;
    end else if (en_in) begin
      cnt_q <= last_out ? 4'd0 : cnt_q + 4'd1;
    end
    if (rst_in) buf_q <= '0;
    else if (en_in) buf_q <= buf_d;
  end

endmodule

// File: rtl/model_loader.sv
// model_loader: framed byte-stream writer for model memory.
// Trailing checksum byte enabled by MODEL_LOADER_CHECKSUM_EN.
module model_loader
  import model_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [7:0]       byte_in,
  output logic             write_valid_out,
  output logic [1:0]       write_target_out,
  output logic [11:0]      write_id_out,
  output logic [2:0][31:0] write_data_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             error_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef MODEL_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    Idle, Target, CountLo, CountHi, Data, Check
  } state_e;
`else
  typedef enum logic [2:0] {
    Idle, Target, CountLo, CountHi, Data
  } state_e;
`endif

  state_e           state_q, state_d;
  target_e          tgt_q;
  logic [7:0]       cnt_lo_q;
  logic [12:0]      left_q;
  logic [11:0]      id_q;
  logic [TW-1:0]    tmo_q;
  logic [15:0]      cnt_full;
  logic             done_d, err_d, tmo_exp;
  logic             in_data, pk_last;
  logic [2:0][31:0] pk_data;
`ifdef MODEL_LOADER_CHECKSUM_EN
  logic [7:0]       cks_q;
`endif

  assign cnt_full = {byte_in, cnt_lo_q};
  assign in_data  = (state_q == Data);

  loader_record_packer u_packer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr_in    (!in_data),
    .en_in     (valid_in && in_data),
    .byte_in   (byte_in),
    .target_in (tgt_q),
    .last_out  (pk_last),
    .data_out  (pk_data)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= Idle;
    else state_q <= state_d;
  end

  // Packet framing decisions, timeout first.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tmo_exp = (state_q != Idle) && !valid_in &&
              (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    if (tmo_exp) begin
      err_d   = 1'b1;
      state_d = Idle;
    end else if (valid_in) begin
      unique case (state_q)
        Idle: begin
          if (byte_in == SYNC_BYTE) state_d = Target;
        end
        Target: begin
          if (byte_in > 8'd2) begin
            err_d   = 1'b1;
            state_d = Idle;
          end else begin
            state_d = CountLo;
          end
        end
        CountLo: state_d = CountHi;
        CountHi: begin
          if (cnt_full > 16'(MAX_RECORDS)) begin
            err_d   = 1'b1;
            state_d = Idle;
          end else if (cnt_full == 16'd0) begin
`ifdef MODEL_LOADER_CHECKSUM_EN
            state_d = Check;
`else
            done_d  = 1'b1;
            state_d = Idle;
`endif
          end else begin
            state_d = Data;
          end
        end
        Data: begin
          if (pk_last && left_q == 13'd1) begin
`ifdef MODEL_LOADER_CHECKSUM_EN
            state_d = Check;
`else
            done_d  = 1'b1;
            state_d = Idle;
`endif
          end
        end
`ifdef MODEL_LOADER_CHECKSUM_EN
        Check: begin
          if (byte_in == cks_q) done_d = 1'b1;
          else err_d = 1'b1;
          state_d = Idle;
        end
`endif
        default: state_d = Idle;
      endcase
    end
  end

  // Header fields, record bookkeeping, registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tgt_q            <= IndexTarget;
      cnt_lo_q         <= '0;
      left_q           <= '0;
      id_q             <= '0;
      tmo_q            <= '0;
      write_valid_out  <= 1'b0;
      write_target_out <= '0;
      write_id_out     <= '0;
      write_data_out   <= '0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      error_out        <= 1'b0;
    end else begin
      if (state_q == Idle || valid_in) tmo_q <= '0;
      else tmo_q <= tmo_q + 1'b1;
      if (valid_in) begin
        if (state_q == Idle && byte_in == SYNC_BYTE)
          id_q <= '0;
        if (state_q == Target)
          tgt_q <= target_e'(byte_in[1:0]);
        if (state_q == CountLo)
          cnt_lo_q <= byte_in;
        if (state_q == CountHi)
          left_q <= cnt_full[12:0];
      end
      if (pk_last) begin
        left_q <= left_q - 13'd1;
        if (id_q != 12'hFFF) id_q <= id_q + 12'd1;
        write_target_out <= tgt_q;
        write_id_out     <= id_q;
        write_data_out   <= pk_data;
      end
      write_valid_out <= pk_last;
      busy_out        <= (state_d != Idle);
      done_out        <= done_d;
      error_out       <= err_d;
    end
  end

`ifdef MODEL_LOADER_CHECKSUM_EN
  // Running XOR of header and record bytes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cks_q <= '0;
    end else if (valid_in) begin
      if (state_q == Idle) cks_q <= '0;
      else if (state_q != Check) cks_q <= cks_q ^ byte_in;
    end
  end
`endif

endmodule

// File: tb/tb_model_loader.sv
// tb_model_loader: table vectors, corner sequences, random packets.
// Reference model derives records from the packet format directly.
module tb_model_loader;
  import model_pkg::*;

  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             rst, valid;
  logic [7:0]       bt;
  logic             write_valid_out;
  logic [1:0]       write_target_out;
  logic [11:0]      write_id_out;
  logic [2:0][31:0] write_data_out;
  logic             busy_out, done_out, error_out;

  model_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .valid_in         (valid),
    .byte_in          (bt),
    .write_valid_out  (write_valid_out),
    .write_target_out (write_target_out),
    .write_id_out     (write_id_out),
    .write_data_out   (write_data_out),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .error_out        (error_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       tgt;
    logic [11:0]      id;
    logic [2:0][31:0] data;
  } wr_t;

  typedef struct {
    int               len;
    logic [23:0][7:0] b;
    logic [7:0]       cks;
    bit               has_cks;
    int               nwr;
    int               dn;
    int               er;
    wr_t              w0;
  } vec_t;

  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  wr_t  got_q[$];
  int   got_cyc[$];
  int   n_done, n_err, done_cyc;
  wr_t  exp_q[$];
  int   exp_done, exp_err;
  logic [7:0] pkt[$];
  logic [7:0] tmp[$];
  vec_t tv[7];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write_valid_out) begin
      got_q.push_back('{write_target_out, write_id_out,
                        write_data_out});
      got_cyc.push_back(cyc);
    end
    if (done_out) begin
      n_done = n_done + 1;
      done_cyc = cyc;
    end
    if (error_out) n_err = n_err + 1;
  end

  initial begin
    #950_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    valid = 1'b1;
    bt = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      bt = 8'h00;
    end
  endtask

  task automatic clear();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    pkt.delete();
    n_done = 0;
    n_err = 0;
    exp_done = 0;
    exp_err = 0;
  endtask

  task automatic load(input int i, input logic [7:0] ck,
                      input bit hc, input int nw,
                      input int dn, input int er,
                      input wr_t w);
    tv[i].len = tmp.size();
    tv[i].b = '0;
    foreach (tmp[j]) tv[i].b[j] = tmp[j];
    tv[i].cks = ck;
    tv[i].has_cks = hc;
    tv[i].nwr = nw;
    tv[i].dn = dn;
    tv[i].er = er;
    tv[i].w0 = w;
  endtask

  // Model: build a well-formed packet and its expected writes.
  task automatic gen_good(input int t, input int n,
                          input bit bad_cks);
    logic [7:0]       c;
    logic [2:0][31:0] d;
    logic [31:0]      v;
    int               st;
    st = pkt.size();
    pkt.push_back(SYNC_BYTE);
    pkt.push_back(8'(t));
    pkt.push_back(8'(n % 256));
    pkt.push_back(8'(n / 256));
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < 3; k++) begin
        if (t == 0) begin
          v = $urandom_range(0, 65535);
          pkt.push_back(v[7:0]);
          pkt.push_back(v[15:8]);
          d[k] = v % 4096;
        end else begin
          v = $urandom;
          for (int j = 0; j < 4; j++)
            pkt.push_back(8'((v >> (8 * j)) % 256));
          d[k] = v;
        end
      end
      exp_q.push_back('{2'(t), 12'(r), d});
    end
    c = 8'h00;
    for (int i = st + 1; i < pkt.size(); i++) c = c ^ pkt[i];
`ifdef MODEL_LOADER_CHECKSUM_EN
    pkt.push_back(bad_cks ? (c ^ 8'h5A) : c);
    if (bad_cks) exp_err++;
    else exp_done++;
`else
    if (bad_cks || !bad_cks) exp_done++;
`endif
  endtask

  task automatic drive_pkt(input int maxgap);
    foreach (pkt[i]) begin
      send(pkt[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
    idle(4);
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, " nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, " wr"}, got_q[i], exp_q[i]);
    chk({tag, " done"}, n_done, exp_done);
    chk({tag, " err"}, n_err, exp_err);
    chk({tag, " busy"}, busy_out, 1'b0);
  endtask

  initial begin
    int   kind, t, n, lat, c0;
    bit   seen;
    wr_t  g0;

    rst = 1'b1;
    valid = 1'b0;
    bt = 8'h00;
    n_done = 0;
    n_err = 0;
    done_cyc = 0;
    repeat (3) @(negedge clk);
    chk("reset wv", write_valid_out, 1'b0);
    chk("reset wr", {write_target_out, write_id_out,
                     write_data_out}, '0);
    chk("reset flags", {busy_out, done_out, error_out}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    tmp = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00,
            8'h02, 8'h00, 8'h03, 8'h00};
    load(0, 8'h01, 1, 1, 1, 0,
         '{2'd0, 12'd0, {32'd3, 32'd2, 32'd1}});
    tmp = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h80, 8'hBF};
    load(1, 8'h80, 1, 1, 1, 0,
         '{2'd1, 12'd0, {32'hBF800000, 32'h0, 32'h3F800000}});
    tmp = '{8'hA5, 8'h05};
    load(2, 8'h00, 0, 0, 0, 1, '0);
    tmp = '{8'hA5, 8'h00, 8'h01, 8'h10};
    load(3, 8'h00, 0, 0, 0, 1, '0);
    tmp = '{8'hA5, 8'h02, 8'h00, 8'h00};
    load(4, 8'h02, 1, 0, 1, 0, '0);
    tmp = '{8'h11, 8'h22, 8'hA5, 8'h00, 8'h01, 8'h00,
            8'hFF, 8'hFF, 8'h34, 8'h12, 8'h00, 8'hF0};
    load(5, 8'hD7, 1, 1, 1, 0,
         '{2'd0, 12'd0, {32'h0, 32'h234, 32'hFFF}});
    tmp = '{8'hA5, 8'h03};
    load(6, 8'h00, 0, 0, 0, 1, '0);

    for (int i = 0; i < 7; i++) begin
      clear();
      for (int j = 0; j < tv[i].len; j++) send(tv[i].b[j]);
`ifdef MODEL_LOADER_CHECKSUM_EN
      if (tv[i].has_cks) send(tv[i].cks);
`endif
      idle(4);
      g0 = (got_q.size() > 0) ? got_q[0] : '0;
      chk($sformatf("tv%0d nwr", i), got_q.size(), tv[i].nwr);
      chk($sformatf("tv%0d done", i), n_done, tv[i].dn);
      chk($sformatf("tv%0d err", i), n_err, tv[i].er);
      chk($sformatf("tv%0d w0", i), g0, tv[i].w0);
      chk($sformatf("tv%0d busy", i), busy_out, 1'b0);
    end

    // Three normal records at full rate.
    clear();
    gen_good(2, 3, 0);
    drive_pkt(0);
    cmp_all("n3");
    if (got_cyc.size() == 3) begin
      chk("n3 gap01", got_cyc[1] - got_cyc[0], 12);
      chk("n3 gap12", got_cyc[2] - got_cyc[1], 12);
`ifdef MODEL_LOADER_CHECKSUM_EN
      chk("n3 done at", done_cyc, got_cyc[2] + 1);
`else
      chk("n3 done at", done_cyc, got_cyc[2]);
`endif
    end

    // Maximum record count: ids run 0..4095.
    clear();
    gen_good(0, 4096, 0);
    drive_pkt(0);
    cmp_all("max");

    // Back-to-back packets.
    clear();
    gen_good(1, 2, 0);
    gen_good(0, 1, 0);
    drive_pkt(0);
    cmp_all("b2b");

    // Stall mid-record until timeout.
    clear();
    send(8'hA5); send(8'h01); send(8'h01); send(8'h00);
    for (int k = 0; k < 5; k++) send(8'($urandom_range(0, 255)));
    idle(1);
    c0 = cyc;
    seen = 0;
    lat = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (error_out) begin
        seen = 1;
        lat = cyc - c0;
        chk("tmo busy", busy_out, 1'b0);
      end
    end
    chk("tmo latency", lat, TMO);
    idle(2);
    chk("tmo nwr", got_q.size(), 0);
    chk("tmo done", n_done, 0);

    // Reset mid-record, then a clean packet from id 0.
    clear();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33);
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(TMO + 4);
    chk("rst nwr", got_q.size(), 0);
    chk("rst pulses", n_done + n_err, 0);
    chk("rst busy", busy_out, 1'b0);
    clear();
    gen_good(0, 1, 0);
    drive_pkt(0);
    cmp_all("post rst");

`ifdef MODEL_LOADER_CHECKSUM_EN
    // Wrong checksum: writes stand, error instead of done.
    clear();
    gen_good(0, 1, 1);
    drive_pkt(0);
    cmp_all("bad cks");
`endif

    // Randomized packets against the model.
    for (int p = 0; p < 40; p++) begin
      clear();
      repeat ($urandom_range(0, 2))
        pkt.push_back(8'($urandom_range(0, 8'hA4)));
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        pkt.push_back(SYNC_BYTE);
        pkt.push_back(8'($urandom_range(3, 255)));
        exp_err = 1;
      end else if (kind == 1) begin
        n = $urandom_range(4097, 65535);
        pkt.push_back(SYNC_BYTE);
        pkt.push_back(8'($urandom_range(0, 2)));
        pkt.push_back(8'(n % 256));
        pkt.push_back(8'(n / 256));
        exp_err = 1;
      end else begin
        t = $urandom_range(0, 2);
        n = $urandom_range(0, 3);
        gen_good(t, n, kind == 2);
      end
      drive_pkt(2);
      cmp_all($sformatf("rnd%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/model_loader.md
# model_loader

Byte-stream writer for the model memory: parses framed packets arriving one byte per strobe (e.g. from a UART receiver) and issues one write per assembled record into the index, position or normal region. It is the write-side counterpart of the read ports used by vertex fetch and the fragment shader, and sits between the host link and the model memory write port in the gpu clock domain.

## Interface
- TIMEOUT_CYCLES, 1_000_000: idle cycles allowed between bytes inside a packet before abort.
- clk_in  input  1  gpu clock. Single clock domain.
- rst_in  input  1  reset. Synchronous, active-high.
- valid_in  input  1  byte strobe. One byte per asserted cycle; may assert every cycle; no backpressure.
- byte_in  input  8  stream byte.
- write_valid_out  output  1  one-cycle write strobe.
- write_target_out  output  2  0 index, 1 position, 2 normal.
- write_id_out  output  12  record address.
- write_data_out  output  [2:0][31:0]  record. For index target: lane k [11:0] = index k, bits [31:12] zero.
- busy_out  output  1  high from sync byte until packet end.
- done_out  output  1  one-cycle pulse: packet completed successfully.
- error_out  output  1  one-cycle pulse: packet aborted.

## Operation
- Packet: 0xA5 sync, target byte, count low, count high, count records, then (with checksum) one checksum byte.
- Count: 16-bit little-endian; valid range 0..4096. Count > 4096 -> error.
- Target byte > 2 -> error.
- Index record: 6 bytes, three little-endian 16-bit values, low 12 bits kept, high 4 bits ignored.
- Position/normal record: 12 bytes, x, y, z each little-endian fp32.
- Record ids start at 0, increment by 1 per record, no wrap (max 4095).
- States: Idle, Target, CountLo, CountHi, Data, Check.
  - Idle: non-0xA5 bytes discarded; 0xA5 -> Target.
  - Target -> CountLo -> CountHi on each byte.
  - CountHi: count 0 -> Check (with checksum) or done and Idle (without); else -> Data.
  - Data: bytes packed into record register; last byte of record -> write; last byte of last record -> Check or done.
  - Check: compare byte to checksum -> done or error; -> Idle.
- Error: pulse error_out, return to Idle; writes already issued stand.
- Timeout: in any state except Idle, TIMEOUT_CYCLES consecutive cycles without valid_in -> error, Idle. Counter resets on every accepted byte.

## Timing
- Reset: all outputs 0, state Idle, id 0, byte counter 0, checksum 0, timeout counter 0.
- Write latency: write_valid_out, target, id and data registered; valid on the cycle after the record's final byte. Outputs other than the strobe hold until the next write.
- done_out/error_out: cycle after the deciding byte (or timeout expiry). Without checksum, done_out coincides with the last write_valid_out.
- busy_out: rises cycle after sync byte; falls with the done/error pulse.
- Back-to-back: a new 0xA5 in the cycle right after packet end is accepted.
- Reset mid-packet: no write, no done/error pulse; Idle next cycle.

## Configuration
- MODEL_LOADER_CHECKSUM_EN defined: Check state present; checksum = XOR of every byte after sync through the last record byte; trailing byte must match, mismatch -> error_out, no done_out.
- Undefined: no Check state, no trailing byte; done_out after last record (or at CountHi for count 0).

## Structure
- Shared package model_pkg: SYNC_BYTE (0xA5), target enum (IndexTarget=0, PositionTarget=1, NormalTarget=2), MAX_RECORDS (4096); same enum used by model_memory's write port.
- One sub-module: loader_record_packer — byte shift/pack into [2:0][31:0] per target, byte-within-record counter, record-complete flag.

## Test plan
- A5 00 01 00 01 00 02 00 03 00 [01] -> one write: target 0, id 0, lanes 1,2,3; done_out; checksum 0x01 passes with macro.
- A5 01 01 00 00 00 80 3F 00 00 00 00 00 00 80 BF [cks] -> target 1, id 0, data {3F800000, 00000000, BF800000}; done_out.
- Normal packet count 3 with valid_in every cycle -> ids 0,1,2 in order, writes 12 cycles apart; done_out once.
- Target byte 0x05, or count 0x1001 -> error_out, no writes, next A5 packet loads normally.
- Stall mid-record for TIMEOUT_CYCLES (set 16) -> error_out at cycle 16, busy_out low; with macro, wrong checksum byte -> error_out, no done_out.
- rst_in asserted mid-record -> no write_valid_out, no pulses, next packet writes from id 0.
